// File: rtl/serial_adder_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl_pkg
//  Shared definitions for the bit-serial adder slice:
//   - DEF_WIDTH : default operand/result width
//   - state_e   : controller states (IDLE=0, ADD=1, DONE=2)
// -----------------------------------------------------------------------------
package serial_adder_ctrl_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage : serial_adder_ctrl_pkg

// File: rtl/serial_adder_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl_if
//  Request/response bundle between a requester and the serial adder.
//   start        : request, accepted only when the adder is idle or done
//   a, b, c_in   : operands and carry-in, captured on the accepting edge
//   busy         : addition in progress
//   done         : one-cycle result-valid pulse
//   sum, c_out   : result, held until the next result is produced
//  Modports: master = requester side, slave = adder side.
// -----------------------------------------------------------------------------
interface serial_adder_ctrl_if
   import serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             c_out;

   modport master (
      output start, a, b, c_in,
      input  busy, done, sum, c_out
   );

   modport slave (
      input  start, a, b, c_in,
      output busy, done, sum, c_out
   );

endinterface : serial_adder_ctrl_if

// File: rtl/serial_adder_ctrl_fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
//  Single 1-bit full adder built from and/or/not gates in sum-of-products form.
//   a, b, c_in : input bits
//   sum        : a ^ b ^ c_in (as four minterms)
//   c_out      : majority(a, b, c_in)
// -----------------------------------------------------------------------------
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic c_out
);

   logic na, nb, nc;
   logic m1, m2, m4, m7;
   logic p_ab, p_ac, p_bc;

   not u_na (na, a);
   not u_nb (nb, b);
   not u_nc (nc, c_in);

   // Odd-parity minterms: 001, 010, 100, 111 (a b c_in).
   and u_m1 (m1, na, nb, c_in);
   and u_m2 (m2, na, b,  nc);
   and u_m4 (m4, a,  nb, nc);
   and u_m7 (m7, a,  b,  c_in);
   or  u_s  (sum, m1, m2, m4, m7);

   and u_ab (p_ab, a, b);
   and u_ac (p_ac, a, c_in);
   and u_bc (p_bc, b, c_in);
   or  u_co (c_out, p_ab, p_ac, p_bc);

endmodule : fa_cell

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//  Bit-serial WIDTH-bit adder. One fa_cell adds the operands LSB-first, one bit
//  per clock. A request is accepted when start is high in IDLE or DONE; the
//  result appears with a one-cycle done pulse WIDTH cycles after acceptance.
//  Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_adder_ctrl_if.slave (start/a/b/c_in in, busy/done/sum/c_out out)
//  sum/c_out are registered and only update when a full result is ready.
// -----------------------------------------------------------------------------
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   serial_adder_ctrl_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_e           state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic             carry_q,   carry_d;
   logic [WIDTH-1:0] shift_a_q, shift_a_d;
   logic [WIDTH-1:0] shift_b_q, shift_b_d;
   logic [WIDTH-1:0] res_q,     res_d;
   logic [WIDTH-1:0] sum_q,     sum_d;
   logic             c_out_q,   c_out_d;
   logic             done_q,    done_d;

   logic cell_sum;
   logic cell_c_out;

   fa_cell u_fa_cell (
      .a     (shift_a_q[0]),
      .b     (shift_b_q[0]),
      .c_in  (carry_q),
      .sum   (cell_sum),
      .c_out (cell_c_out)
   );

   // NOTE: every _d signal is given its hold value before the case statement,
   // so no path through the block leaves it unassigned and no latch appears.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      shift_a_d = shift_a_q;
      shift_b_d = shift_b_q;
      res_d     = res_q;
      sum_d     = sum_q;
      c_out_d   = c_out_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // A start in DONE is accepted back-to-back; the pulse for the
            // previous result is already on done_q this cycle.
            if (bus.start) begin
               shift_a_d = bus.a;
               shift_b_d = bus.b;
               carry_d   = bus.c_in;
               res_d     = '0;
               cnt_d     = '0;
               state_d   = ST_ADD;
            end else begin
               state_d   = ST_IDLE;
            end
         end

         ST_ADD: begin
            // Result bits enter at the MSB so after WIDTH shifts the LSB
            // computed first sits at bit 0.
            res_d     = {cell_sum, res_q[WIDTH-1:1]};
            carry_d   = cell_c_out;
            shift_a_d = shift_a_q >> 1;
            shift_b_d = shift_b_q >> 1;
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               sum_d   = {cell_sum, res_q[WIDTH-1:1]};
               c_out_d = cell_c_out;
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_DONE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: the operand and result shift registers are plain flops, not a
   // memory, so they take the reset like every other piece of state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         carry_q   <= 1'b0;
         shift_a_q <= '0;
         shift_b_q <= '0;
         res_q     <= '0;
         sum_q     <= '0;
         c_out_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every flop samples pre-edge values.
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         carry_q   <= carry_d;
         shift_a_q <= shift_a_d;
         shift_b_q <= shift_b_d;
         res_q     <= res_d;
         sum_q     <= sum_d;
         c_out_q   <= c_out_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy  = (state_q == ST_ADD);
   assign bus.done  = done_q;
   assign bus.sum   = sum_q;
   assign bus.c_out = c_out_q;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//  Directed and randomized checks of serial_adder_ctrl at WIDTH=8.
//  Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;
   import serial_adder_ctrl_pkg::*;

   localparam int W = 8;
   localparam int LAT = W;
   localparam int MAX_WAIT = 20;

   logic clk;
   logic rst_n;

   int n_checks = 0;
   int n_errors = 0;

   serial_adder_ctrl_if #(.WIDTH(W)) bus ();

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // One complete operation: accept, wait for done (bounded), check the
   // latency, the result, that sum/c_out never moved early, and pulse width.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic [W-1:0] exp_sum, input logic exp_c, input string tag);
      logic [W-1:0] prev_sum;
      logic         prev_c;
      int           lat;
      int           busy_n;
      logic         held;
      prev_sum = bus.sum;
      prev_c   = bus.c_out;
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.c_in  = cin;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = ~a;
      bus.b     = ~b;
      bus.c_in  = ~cin;
      lat = 0;
      busy_n = 0;
      held = 1'b1;
      while (!bus.done && lat < MAX_WAIT) begin
         if (bus.busy) busy_n++;
         if (bus.sum !== prev_sum || bus.c_out !== prev_c) held = 1'b0;
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, lat, LAT);
      check({tag, " busy_cycles"}, busy_n, LAT);
      check({tag, " no_partial"}, {31'd0, held}, 32'd1);
      check({tag, " sum"}, bus.sum, exp_sum);
      check({tag, " c_out"}, bus.c_out, exp_c);
      @(negedge clk);
      check({tag, " done_width"}, bus.done, 0);
      check({tag, " idle_busy"}, bus.busy, 0);
      check({tag, " sum_hold"}, bus.sum, exp_sum);
   endtask

   initial begin : main
      logic [W:0]   model;
      logic [W-1:0] ra, rb;
      logic         rc;
      logic [W-1:0] corners [3];
      int           lat;
      int           busy_n;
      logic         seen_done;

      corners[0] = 8'h00;
      corners[1] = 8'h80;
      corners[2] = 8'hFF;

      rst_n     = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.c_in  = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("reset busy",  bus.busy,  0);
      check("reset done",  bus.done,  0);
      check("reset sum",   bus.sum,   0);
      check("reset c_out", bus.c_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Hand-computed vectors.
      run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "5a+3c");
      run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff+01");
      run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ff+ff+1");

      // Start pulsed while busy must be ignored.
      bus.start = 1'b1;
      bus.a = 8'h10;
      bus.b = 8'h20;
      bus.c_in = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 0;
      busy_n = 0;
      while (!bus.done && lat < MAX_WAIT) begin
         if (bus.busy) busy_n++;
         bus.start = (lat == 3);
         bus.a = 8'h01;
         bus.b = 8'h01;
         @(negedge clk);
         lat++;
      end
      bus.start = 1'b0;
      check("busy_start latency", lat, LAT);
      check("busy_start busy_cycles", busy_n, LAT);
      check("busy_start sum", bus.sum, 8'h30);
      check("busy_start c_out", bus.c_out, 0);
      @(negedge clk);
      check("busy_start done_width", bus.done, 0);
      check("busy_start idle", bus.busy, 0);

      // Back-to-back: start held high through DONE.
      bus.start = 1'b1;
      bus.a = 8'h03;
      bus.b = 8'h04;
      bus.c_in = 1'b0;
      @(negedge clk);
      lat = 0;
      while (!bus.done && lat < MAX_WAIT) begin
         @(negedge clk);
         lat++;
      end
      check("b2b first latency", lat, LAT);
      check("b2b first sum", bus.sum, 8'h07);
      bus.a = 8'h7F;
      bus.b = 8'h01;
      @(negedge clk);
      bus.start = 1'b0;
      check("b2b busy_after_done", bus.busy, 1);
      check("b2b done_width", bus.done, 0);
      check("b2b sum_held", bus.sum, 8'h07);
      lat = 0;
      while (!bus.done && lat < MAX_WAIT) begin
         @(negedge clk);
         lat++;
      end
      check("b2b second latency", lat, LAT);
      check("b2b second sum", bus.sum, 8'h80);
      check("b2b second c_out", bus.c_out, 0);
      @(negedge clk);
      check("b2b second done_width", bus.done, 0);
      check("b2b idle", bus.busy, 0);

      // Reset in the middle of an operation.
      bus.start = 1'b1;
      bus.a = 8'hAA;
      bus.b = 8'h55;
      bus.c_in = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst busy",  bus.busy,  0);
      check("midrst done",  bus.done,  0);
      check("midrst sum",   bus.sum,   0);
      check("midrst c_out", bus.c_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) seen_done = 1'b1;
      end
      check("midrst no_done", {31'd0, seen_done}, 0);
      run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "after_rst");

      // Corner operands against a + b + c_in.
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < 2; k++) begin
               model = {1'b0, corners[i]} + {1'b0, corners[j]} + (W+1)'(k);
               run_op(corners[i], corners[j], k[0], model[W-1:0], model[W], "corner");
            end
         end
      end

      // Random triples.
      for (int n = 0; n < 512; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         model = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
         run_op(ra, rb, rc, model[W-1:0], model[W], "random");
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_serial_adder_ctrl
